dram_bank_responder: RTL and testbench
======================================

DRAM_BANK_RESPONDER -- requirements
Module: dram_bank_responder

Interface
REQ-001 The block SHALL have parameter TRCD_CYCLES, default 8, activate-to-CAS delay in cycles.
REQ-002 The block SHALL have parameter TCL_CYCLES, default 8, CAS-to-first-beat delay in cycles.
REQ-003 The block SHALL have parameter TRP_CYCLES, default 8, precharge duration in cycles.
REQ-004 The block SHALL have parameter TWR_CYCLES, default 7, write-recovery duration in cycles.
REQ-005 The block SHALL have parameter BURST_LEN, default 4, beats per access.
REQ-006 The block SHALL have parameter BURST_ACCESS_WIDTH, default 64, bits per beat.
REQ-007 The block SHALL have parameter NUM_ROWS, default 100, rows backed by storage.
REQ-008 The block SHALL have parameter ADDRESS_LEN, default 10, row-address width.
REQ-009 The block SHALL have ports:
  clk  in  1  sole clock, rising edge;
  rst_n  in  1  asynchronous active-low reset;
  req_valid  in  1  initiator request;
  req_ready  out  1  responder can accept;
  req_we  in  1  1=write, 0=read;
  req_addr  in  ADDRESS_LEN  row address;
  wr_data  in  BURST_ACCESS_WIDTH  write beat, sampled while wr_beat=1;
  wr_beat  out  1  write beat being sampled this cycle;
  rd_valid  out  1  read beat valid;
  rd_data  out  BURST_ACCESS_WIDTH  read beat;
  rd_last  out  1  final read beat;
  done  out  1  one-cycle completion pulse;
  err  out  1  out-of-range flag, valid with done;
  busy  out  1  access in progress.

Function
REQ-010 Storage SHALL be NUM_ROWS rows of BURST_LEN x BURST_ACCESS_WIDTH bits; beat k maps to bits [k*W +: W].
REQ-011 Handshake SHALL occur when req_valid and req_ready are both 1 at a rising edge; req_we and req_addr are captured then.
REQ-012 req_ready SHALL equal 1 only in IDLE; busy SHALL equal NOT req_ready.
REQ-013 FSM states SHALL be IDLE, ACT, CAS, BURST, WREC, PRE (closed-page policy).
REQ-014 Transitions SHALL be: IDLE->ACT on handshake; ACT->CAS after TRCD_CYCLES; CAS->BURST after TCL_CYCLES; BURST->WREC (write) or PRE (read) after BURST_LEN; WREC->PRE after TWR_CYCLES; PRE->IDLE after TRP_CYCLES.
REQ-015 With handshake at edge T, the BURST beats SHALL occupy cycles T+TRCD+TCL+1 .. T+TRCD+TCL+BURST_LEN, beat 0 first.
REQ-016 Reads SHALL drive rd_valid=1 with rd_data = beat k in burst cycle k, and rd_last=1 only in beat BURST_LEN-1; otherwise rd_valid, rd_last SHALL be 0 and rd_data 0.
REQ-017 Writes SHALL drive wr_beat=1 in each burst cycle and store wr_data into beat k at that edge.
REQ-018 done SHALL pulse for exactly one cycle, the first IDLE cycle after PRE, coincident with req_ready=1.
REQ-019 Total occupancy SHALL be TRCD+TCL+BURST_LEN+TRP cycles for reads (28 default) and plus TWR_CYCLES for writes (35 default).
REQ-020 A request with req_addr >= NUM_ROWS SHALL run full timing, return all-zero read beats, discard write data, and assert err with done.
REQ-021 err SHALL be 0 whenever done is 0.
REQ-022 A back-to-back handshake in the done cycle SHALL be accepted (no idle gap required).
REQ-023 Inputs other than wr_data SHALL be ignored while busy=1.
REQ-024 Phase counters SHALL be sized for the largest of the timing parameters and BURST_LEN; a parameter value of 1 SHALL yield a one-cycle phase.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, all counters 0, and outputs req_ready=1, busy=0, wr_beat=0, rd_valid=0, rd_data=0, rd_last=0, done=0, err=0.
REQ-026 Reset mid-operation SHALL abort the access with no done pulse; storage contents SHALL NOT be reset, and a write aborted mid-burst leaves already-written beats updated.
REQ-027 The first handshake SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-028 Write row 5 beats {A0,A1,A2,A3}: wr_beat cycles T+17..T+20, done at T+36, err=0.
REQ-029 Then read row 5: rd_valid T+17..T+20 with A0..A3, rd_last at T+20, done at T+29.
REQ-030 Read row 100 (out-of-range): four zero beats, done with err=1 at T+29; a subsequent write to row 100 alters no row.
REQ-031 Issue a read with req_valid held high through done: second handshake at the done cycle, next first beat exactly 29 cycles later.
REQ-032 Assert rst_n=0 at T+18 of a read: all outputs at reset values immediately, no done; after release, req_ready=1 and a read of that row returns the prior data.
REQ-033 Toggle req_valid/req_addr while busy: no effect on timing or returned data.

Source files
------------

// File: rtl/dram_bank_responder.sv
// rtl/dram_bank_responder.sv - single-bank DRAM responder with closed-page ACT/CAS/BURST/WREC/PRE timing
module dram_bank_responder #(
  parameter int TRCD_CYCLES        = 8,
  parameter int TCL_CYCLES         = 8,
  parameter int TRP_CYCLES         = 8,
  parameter int TWR_CYCLES         = 7,
  parameter int BURST_LEN          = 4,
  parameter int BURST_ACCESS_WIDTH = 64,
  parameter int NUM_ROWS           = 100,
  parameter int ADDRESS_LEN        = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDRESS_LEN-1:0]        req_addr,
  input  logic [BURST_ACCESS_WIDTH-1:0] wr_data,
  output logic                          wr_beat,
  output logic                          rd_valid,
  output logic [BURST_ACCESS_WIDTH-1:0] rd_data,
  output logic                          rd_last,
  output logic                          done,
  output logic                          err,
  output logic                          busy
);

  localparam int M1   = (TRCD_CYCLES > TCL_CYCLES) ? TRCD_CYCLES : TCL_CYCLES;
  localparam int M2   = (M1 > TRP_CYCLES) ? M1 : TRP_CYCLES;
  localparam int M3   = (M2 > TWR_CYCLES) ? M2 : TWR_CYCLES;
  localparam int MAXP = (M3 > BURST_LEN) ? M3 : BURST_LEN;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [CW-1:0] TRCD_LAST  = CW'(TRCD_CYCLES - 1);
  localparam logic [CW-1:0] TCL_LAST   = CW'(TCL_CYCLES - 1);
  localparam logic [CW-1:0] TRP_LAST   = CW'(TRP_CYCLES - 1);
  localparam logic [CW-1:0] TWR_LAST   = CW'(TWR_CYCLES - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [ADDRESS_LEN:0] ROWS_LIMIT = (ADDRESS_LEN + 1)'(NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_CAS, S_BURST, S_WREC, S_PRE
  } state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic                     we_q;
  logic [ADDRESS_LEN-1:0]   addr_q;
  logic                     done_q, done_n;
  logic                     err_q;
  logic                     in_range;
  logic [RW-1:0]            row;
  logic [BW-1:0]            beat;

  logic [BURST_LEN-1:0][BURST_ACCESS_WIDTH-1:0] mem [NUM_ROWS];

  assign in_range = {1'b0, addr_q} < ROWS_LIMIT;
  assign row      = addr_q[RW-1:0];
  assign beat     = cnt[BW-1:0];

  // Each phase counts 0..N-1 and hands over on its last count, so N=1 is a single cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_n = S_ACT;
          cnt_n   = '0;
        end
      end
      S_ACT: begin
        if (cnt == TRCD_LAST) begin
          state_n = S_CAS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_CAS: begin
        if (cnt == TCL_LAST) begin
          state_n = S_BURST;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BURST: begin
        if (cnt == BURST_LAST) begin
          state_n = we_q ? S_WREC : S_PRE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WREC: begin
        if (cnt == TWR_LAST) begin
          state_n = S_PRE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PRE: begin
        if (cnt == TRP_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      done_q <= done_n;
      err_q  <= done_n && !in_range;
      if (state == S_IDLE && req_valid) begin
        we_q   <= req_we;
        addr_q <= req_addr;
      end
    end
  end

  // Storage is deliberately never reset; an aborted write keeps the beats already taken.
  always_ff @(posedge clk) begin
    if (wr_beat && in_range) begin
      mem[row][beat] <= wr_data;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = !req_ready;
  assign wr_beat   = (state == S_BURST) && we_q;
  assign rd_valid  = (state == S_BURST) && !we_q;
  assign rd_last   = rd_valid && (cnt == BURST_LAST);
  assign rd_data   = (rd_valid && in_range) ? mem[row][beat] : '0;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dram_bank_responder.sv
// tb/tb_dram_bank_responder.sv - scoreboard bench for dram_bank_responder
module tb_dram_bank_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [63:0] wr_data;
  logic        wr_beat;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        err;
  logic        busy;

  dram_bank_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .wr_data(wr_data), .wr_beat(wr_beat),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] data;
    logic        last;
    logic        err;
  } ev_t;

  ev_t               sb[$];
  int                cyc = 0;
  int                vectors = 0;
  int                miscompares = 0;
  logic [3:0][63:0]  model [128];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Kind: 0 read beat, 1 write beat, 2 done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_event_cycle", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (rd_valid || wr_beat || done) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {61'd0, rd_valid, wr_beat, done}, 64'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          check("event_kind", rd_valid ? 64'd0 : (wr_beat ? 64'd1 : 64'd2), 64'(e.kind));
          if (e.kind == 0) begin
            check("rd_data", rd_data, e.data);
            check("rd_last", 64'(rd_last), 64'(e.last));
          end
          if (e.kind == 2) check("done_err", 64'(err), 64'(e.err));
        end
      end
      if (!rd_valid) check("idle_rd_data_last", {rd_last, rd_data[62:0]} | {63'd0, rd_data[63]}, 64'd0);
      if (!done) check("err_without_done", 64'(err), 64'd0);
      check("busy_vs_ready", 64'(busy), 64'(!req_ready));
    end
  end

  task automatic run_access(input logic we, input logic [9:0] addr, input logic [3:0][63:0] d,
                            input bit hold, input bit toggle, output int h);
    int  n;
    int  done_c;
    bit  in_r;
    req_we    = we;
    req_addr  = addr;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(n < 200), 64'd1);
    h      = cyc;
    in_r   = (addr < 10'd100);
    done_c = h + (we ? 36 : 29);
    for (int k = 0; k < 4; k++) begin
      ev_t e;
      e.cyc  = h + 17 + k;
      e.kind = we ? 1 : 0;
      e.data = (!we && in_r) ? model[addr[6:0]][k] : 64'd0;
      e.last = (k == 3);
      e.err  = 1'b0;
      sb.push_back(e);
    end
    begin
      ev_t e;
      e.cyc = done_c; e.kind = 2; e.data = 64'd0; e.last = 1'b0; e.err = !in_r;
      sb.push_back(e);
    end
    if (we && in_r) model[addr[6:0]] = d;
    while (cyc < done_c) begin
      @(negedge clk);
      if (cyc < done_c && !hold) begin
        if (toggle) begin
          req_valid = 1'($urandom);
          req_addr  = 10'($urandom);
          req_we    = 1'($urandom);
        end else begin
          req_valid = 1'b0;
        end
      end
      if (we && cyc >= h + 17 && cyc <= h + 20) wr_data = d[cyc - h - 17];
      else if (toggle) wr_data = {$urandom, $urandom};
    end
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [3:0][63:0] da, db, dc, dd, dz;
  int h1, h2, rel;

  initial begin
    da = {64'hA3A3_0003_1111_2222, 64'hA2A2_0002_3333_4444, 64'hA1A1_0001_5555_6666, 64'hA0A0_0000_7777_8888};
    db = {64'hB3B3_DEAD_0000_0003, 64'hB2B2_BEEF_0000_0002, 64'hB1B1_CAFE_0000_0001, 64'hB0B0_F00D_0000_0000};
    dc = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    dd = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_5A5A_A5A5, 64'hFFFF_0000_FFFF_0000};
    dz = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; wr_data = '0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_beat", 64'(wr_beat), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_done_err_last", {61'd0, done, err, rd_last}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;

    run_access(1'b1, 10'd5, da, 1'b0, 1'b0, h1);
    check("first_handshake_after_reset", 64'(h1), 64'(rel));
    run_access(1'b0, 10'd5, dz, 1'b0, 1'b0, h1);
    run_access(1'b1, 10'd99, db, 1'b0, 1'b0, h1);
    run_access(1'b0, 10'd99, dz, 1'b0, 1'b0, h1);
    run_access(1'b0, 10'd100, dz, 1'b0, 1'b0, h1);
    run_access(1'b1, 10'd100, dc, 1'b0, 1'b0, h1);
    run_access(1'b0, 10'd5, dz, 1'b0, 1'b0, h1);
    run_access(1'b0, 10'd99, dz, 1'b0, 1'b0, h1);
    run_access(1'b0, 10'd100, dz, 1'b0, 1'b0, h1);
    run_access(1'b1, 10'd1023, dc, 1'b0, 1'b0, h1);
    run_access(1'b0, 10'd99, dz, 1'b0, 1'b0, h1);

    // Back-to-back: request held high through done must be taken in the done cycle.
    run_access(1'b0, 10'd5, dz, 1'b1, 1'b0, h1);
    run_access(1'b0, 10'd99, dz, 1'b0, 1'b0, h2);
    check("back_to_back_gap", 64'(h2 - h1), 64'd29);

    // Inputs toggling while busy must not disturb timing or data.
    run_access(1'b0, 10'd99, dz, 1'b0, 1'b1, h1);
    run_access(1'b1, 10'd5, dd, 1'b0, 1'b1, h1);
    run_access(1'b0, 10'd5, dz, 1'b0, 1'b0, h1);

    // Reset during the burst of a read: only beat 0 appears, then no done.
    @(negedge clk);
    req_we = 1'b0; req_addr = 10'd5; req_valid = 1'b1;
    check("abort_ready", 64'(req_ready), 64'd1);
    h1 = cyc;
    begin
      ev_t e;
      e.cyc = h1 + 17; e.kind = 0; e.data = model[5][0]; e.last = 1'b0; e.err = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < h1 + 17) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rd_valid", 64'(rd_valid), 64'd0);
    check("abort_rd_data", rd_data, 64'd0);
    check("abort_other_outputs", {60'd0, wr_beat, rd_last, done, err}, 64'd0);
    check("abort_sb_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_abort_ready", 64'(req_ready), 64'd1);
    run_access(1'b0, 10'd5, dz, 1'b0, 1'b0, h1);

    repeat (5) @(negedge clk);
    check("final_sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
